// File: rtl/dram_line_requester.sv
// Cache-line requester toward the DRAM control unit: turns one fill or writeback
// into WORDS_PER_LINE word transactions over the dREN/dWEN/ram_wait handshake.
module dram_line_requester #(
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned WORDS_PER_LINE = 8
) (
    input  logic                             CLK,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_W-1:0]                req_addr,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] req_wdata,
    output logic                             resp_valid,
    output logic [WORD_W*WORDS_PER_LINE-1:0] resp_rdata,
    output logic                             dREN,
    output logic                             dWEN,
    output logic [ADDR_W-1:0]                address,
    output logic [WORD_W-1:0]                ramstore,
    input  logic [WORD_W-1:0]                ramload,
    input  logic                             ram_wait,
    output logic                             busy
);

    localparam int unsigned IW     = $clog2(WORDS_PER_LINE);
    localparam int unsigned OB     = $clog2(WORD_W / 8);
    localparam int unsigned LB     = IW + OB;
    localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] rdata;
    logic [IW-1:0]     idx;
    logic              last;

    assign last = (idx == IW'(WORDS_PER_LINE - 1));

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
            line  <= '0;
            rdata <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base  <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
                        line  <= req_wdata;
                        idx   <= '0;
                        state <= req_write ? WRITE : READ;
                    end
                end
                READ, WRITE: begin
                    // A word completes only when the controller is not stalling us.
                    if (!ram_wait) begin
                        if (state == READ) begin
                            rdata[idx*WORD_W +: WORD_W] <= ramload;
                        end
                        idx <= idx + IW'(1);
                        if (last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dREN       = (state == READ);
        dWEN       = (state == WRITE);
        busy       = (state != IDLE);
        req_ready  = (state == IDLE);
        resp_valid = (state == DONE);
        resp_rdata = rdata;
        address    = '0;
        ramstore   = '0;
        if (dREN || dWEN) begin
            address = base + (ADDR_W'(idx) << OB);
        end
        if (dWEN) begin
            ramstore = line[idx*WORD_W +: WORD_W];
        end
    end

endmodule
